// File: rtl/decoder_skid.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | decoder_skid : one-hot / thermometer / inverted decoder, 2-entry skid out  |
// | Revision 1.0 : initial release                                             |
// +----------------------------------------------------------------------------+
module decoder_skid #(
  parameter int IN_W  = 4,
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  binary_in,
  input  logic [1:0]       mode,
  input  logic             enable,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] decoder_out,
  output logic             range_err,
  output logic [7:0]       err_cnt
);

  localparam logic [1:0]  c_MODE_ONEHOT = 2'b00;
  localparam logic [1:0]  c_MODE_THERMO = 2'b01;
  localparam logic [1:0]  c_MODE_INVERT = 2'b10;
  localparam logic [31:0] c_OUT_W_U     = 32'(OUT_W);

  generate
    if (OUT_W < 2 || OUT_W > 2**IN_W) begin : g_bad_out_w
      $error("decoder_skid: OUT_W must lie in 2..2**IN_W");
    end
  endgenerate

  logic [31:0]      w_k;
  logic [OUT_W-1:0] w_dec;
  logic             w_err;
  logic             w_push;
  logic             w_pop;

  // Head entry drives the outputs directly; skid entry catches the word
  // that arrives while the head is stalled.
  logic [OUT_W-1:0] r_head_d,  w_head_d_n;
  logic             r_head_e,  w_head_e_n;
  logic             r_head_v,  w_head_v_n;
  logic [OUT_W-1:0] r_skid_d,  w_skid_d_n;
  logic             r_skid_e,  w_skid_e_n;
  logic             r_skid_v,  w_skid_v_n;
  logic             r_in_ready;
  logic [7:0]       r_err_cnt;

  assign w_k = 32'(binary_in);

  always_comb begin
    w_dec = '0;
    w_err = (mode == 2'b11) || (w_k >= c_OUT_W_U);
    if (!w_err && enable) begin
      for (int i = 0; i < OUT_W; i++) begin
        case (mode)
          c_MODE_ONEHOT: w_dec[i] = (32'(i) == w_k);
          c_MODE_THERMO: w_dec[i] = (32'(i) <= w_k);
          c_MODE_INVERT: w_dec[i] = (32'(i) != w_k);
          default:       w_dec[i] = 1'b0;
        endcase
      end
    end
  end

  assign w_push = in_valid & r_in_ready;
  assign w_pop  = r_head_v & out_ready;

  always_comb begin
    w_head_d_n = r_head_d;
    w_head_e_n = r_head_e;
    w_head_v_n = r_head_v;
    w_skid_d_n = r_skid_d;
    w_skid_e_n = r_skid_e;
    w_skid_v_n = r_skid_v;
    if (w_pop) begin
      if (r_skid_v) begin
        w_head_d_n = r_skid_d;
        w_head_e_n = r_skid_e;
        w_head_v_n = 1'b1;
        w_skid_d_n = w_push ? w_dec : '0;
        w_skid_e_n = w_push & w_err;
        w_skid_v_n = w_push;
      end else begin
        w_head_d_n = w_push ? w_dec : '0;
        w_head_e_n = w_push & w_err;
        w_head_v_n = w_push;
      end
    end else if (w_push) begin
      if (!r_head_v) begin
        w_head_d_n = w_dec;
        w_head_e_n = w_err;
        w_head_v_n = 1'b1;
      end else begin
        w_skid_d_n = w_dec;
        w_skid_e_n = w_err;
        w_skid_v_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head_d   <= '0;
      r_head_e   <= 1'b0;
      r_head_v   <= 1'b0;
      r_skid_d   <= '0;
      r_skid_e   <= 1'b0;
      r_skid_v   <= 1'b0;
      r_in_ready <= 1'b0;
      r_err_cnt  <= 8'd0;
    end else begin
      r_head_d   <= w_head_d_n;
      r_head_e   <= w_head_e_n;
      r_head_v   <= w_head_v_n;
      r_skid_d   <= w_skid_d_n;
      r_skid_e   <= w_skid_e_n;
      r_skid_v   <= w_skid_v_n;
      r_in_ready <= !(w_head_v_n && w_skid_v_n);
      if (w_push && w_err && (r_err_cnt != 8'hFF)) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_head_v;
  assign decoder_out = r_head_d;
  assign range_err   = r_head_e;
  assign err_cnt     = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_decoder_skid.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_decoder_skid : scoreboard bench for decoder_skid (OUT_W 16 and 10)      |
// | Revision 1.0 : initial release                                             |
// +----------------------------------------------------------------------------+
module tb_decoder_skid;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [3:0]  binary_in;
  logic [1:0]  mode;
  logic        enable;
  logic        out_ready;

  logic        ir16, ov16, re16;
  logic [15:0] do16;
  logic [7:0]  ec16;
  logic        ir10, ov10, re10;
  logic [9:0]  do10;
  logic [7:0]  ec10;

  int checks = 0;
  int errors = 0;

  // Each entry: {err16, data16, err10, data10 zero-extended to 16}
  logic [33:0] sb[$];
  logic [15:0] got[$];
  int          ecnt16 = 0;
  int          ecnt10 = 0;
  bit          armed  = 0;
  int          run    = 0;
  int          maxrun = 0;

  decoder_skid #(.IN_W(4), .OUT_W(16)) u_dut16 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir16),
    .binary_in(binary_in), .mode(mode), .enable(enable),
    .out_valid(ov16), .out_ready(out_ready), .decoder_out(do16),
    .range_err(re16), .err_cnt(ec16)
  );

  decoder_skid #(.IN_W(4), .OUT_W(10)) u_dut10 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir10),
    .binary_in(binary_in), .mode(mode), .enable(enable),
    .out_valid(ov10), .out_ready(out_ready), .decoder_out(do10),
    .range_err(re10), .err_cnt(ec10)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [16:0] model(input int k, input int m, input bit en, input int w);
    logic [15:0] d;
    logic [16:0] full;
    bit          err;
    d    = '0;
    full = (17'd1 << w) - 17'd1;
    err  = (m == 3) || (k >= w);
    if (!err && en) begin
      case (m)
        0: d[k] = 1'b1;
        1: for (int i = 0; i <= k; i++) d[i] = 1'b1;
        2: begin d = full[15:0]; d[k] = 1'b0; end
        default: d = '0;
      endcase
    end
    return {err, d};
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      armed = !reset;
    end
  end

  // Monitor: everything sampled here holds until the next rising edge,
  // so handshakes seen now are exactly the ones that edge will perform.
  initial begin
    logic [33:0] e;
    forever begin
      @(negedge clk);
      if (reset) begin
        sb.delete();
        ecnt16 = 0;
        ecnt10 = 0;
        run    = 0;
        check("rst_ov16", ov16, 0); check("rst_ir16", ir16, 0);
        check("rst_do16", do16, 0); check("rst_re16", re16, 0);
        check("rst_ec16", ec16, 0); check("rst_ov10", ov10, 0);
        check("rst_do10", do10, 0); check("rst_ec10", ec10, 0);
      end else begin
        check("ov16", ov16, sb.size() != 0);
        check("ov10", ov10, sb.size() != 0);
        check("ir16", ir16, armed && sb.size() < 2);
        check("ir10", ir10, armed && sb.size() < 2);
        check("ec16", ec16, ecnt16);
        check("ec10", ec10, ecnt10);
        if (!ov16) check("idle_do16", do16, 0);
        if (!ov10) check("idle_do10", do10, 0);
        run    = ov16 ? run + 1 : 0;
        maxrun = (run > maxrun) ? run : maxrun;
        if (ov16 && sb.size() != 0) begin
          e = sb[0];
          check("do16", do16, e[32:17]);
          check("re16", re16, e[33]);
          check("do10", do10, e[15:0]);
          check("re10", re10, e[16]);
          if (out_ready) begin
            void'(sb.pop_front());
            got.push_back(do16);
          end
        end
        if (in_valid && ir16) begin
          e = {model(binary_in, mode, enable, 16), model(binary_in, mode, enable, 10)};
          sb.push_back(e);
          if (e[33] && ecnt16 < 255) ecnt16++;
          if (e[16] && ecnt10 < 255) ecnt10++;
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input int k, input int m, input bit en);
    int n;
    in_valid  = 1'b1;
    binary_in = 4'(k);
    mode      = 2'(m);
    enable    = en;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ir16 && n < 200);
    if (!ir16) check("send_timeout", 0, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; binary_in = '0; mode = '0;
    enable = 1'b1; out_ready = 1'b1;
    #2;
    check("rst_imm_ir", ir16, 0);
    check("rst_imm_ov", ov16, 0);
    idle(3);
    reset = 1'b0;
    idle(2);
    check("post_rst_ir", ir16, 1);

    send(10, 0, 1);
    @(negedge clk);
    check("onehot_A", do16, 16'h0400); check("onehot_A_re", re16, 0);
    idle(1);
    send(3, 1, 1);
    @(negedge clk); check("thermo_3", do16, 16'h000F);
    idle(1);
    send(3, 2, 1);
    @(negedge clk); check("inv_3", do16, 16'hFFF7); check("inv_3_w10", do10, 10'h3F7);
    idle(1);
    send(3, 2, 0);
    @(negedge clk);
    check("inv_dis", do16, 0); check("inv_dis_re", re16, 0); check("inv_dis_ov", ov16, 1);
    idle(1);
    send(5, 3, 1);
    @(negedge clk); check("rsvd_do", do16, 0); check("rsvd_re", re16, 1);
    idle(2);

    out_ready = 1'b0;
    got.delete();
    send(1, 0, 1);
    send(2, 0, 1);
    in_valid = 1'b1; binary_in = 4'd3; mode = 2'd0; enable = 1'b1;
    @(negedge clk); check("bp_ir_full", ir16, 0);
    @(posedge clk); #1 out_ready = 1'b1;
    send(3, 0, 1);
    idle(4);
    check("bp_count", got.size(), 3);
    if (got.size() == 3) begin
      check("bp_w0", got[0], 16'h0002);
      check("bp_w1", got[1], 16'h0004);
      check("bp_w2", got[2], 16'h0008);
    end

    maxrun = 0;
    for (int i = 0; i < 16; i++) send(i, 0, 1);
    idle(4);
    check("thru_run", maxrun, 16);

    out_ready = 1'b0;
    send(6, 0, 1);
    send(7, 1, 1);
    idle(1);
    check("mid_ov_before", ov16, 1);
    reset = 1'b1;
    #1;
    check("mid_ov_imm", ov16, 0); check("mid_do_imm", do16, 0);
    check("mid_ir_imm", ir16, 0); check("mid_ec_imm", ec16, 0);
    idle(2);
    reset = 1'b0;
    @(negedge clk); check("mid_ir_prerel", ir16, 0);
    idle(1);
    check("mid_ir_rel", ir16, 1);
    out_ready = 1'b1;
    idle(3);
    check("mid_no_stale", ov16, 0);

    send(12, 0, 1);
    @(negedge clk);
    check("err10_do", do10, 0); check("err10_re", re10, 1);
    check("err10_ec", ec10, 1); check("err10_w16", do16, 16'h1000);
    idle(1);
    for (int i = 0; i < 300; i++) begin
      if (i % 2 == 0) send(12, 0, 1);
      else send(i % 16, 3, 1);
    end
    idle(4);
    check("sat_ec10", ec10, 255);
    check("sat_ec16", ec16, 150);
    check("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/decoder_skid.md
DECODER_SKID -- requirements
Module: decoder_skid

Interface
REQ-001 SHALL have parameter IN_W, default 4: width of binary_in.
REQ-002 SHALL have parameter OUT_W, default 16: width of decoder_out; legal range 2..2**IN_W, and other values SHALL fail elaboration.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1: binary_in/mode/enable carry a word this cycle.
REQ-006 SHALL have port in_ready, output, 1: block accepts a word this cycle.
REQ-007 SHALL have port binary_in, input, IN_W: index to decode.
REQ-008 SHALL have port mode, input, 2: 00 one-hot, 01 thermometer, 10 inverted one-hot, 11 reserved.
REQ-009 SHALL have port enable, input, 1: 0 forces an all-zero decode of the accepted word.
REQ-010 SHALL have port out_valid, output, 1: decoder_out/range_err hold a word.
REQ-011 SHALL have port out_ready, input, 1: consumer takes the word this cycle.
REQ-012 SHALL have port decoder_out, output, OUT_W: decoded word.
REQ-013 SHALL have port range_err, output, 1: current word had an illegal index or mode.
REQ-014 SHALL have port err_cnt, output, 8: saturating count of accepted words with range_err set.

Function
REQ-015 SHALL accept a word on a rising edge where in_valid and in_ready are both 1, and SHALL ignore all inputs on every other edge.
REQ-016 SHALL decode at acceptance, with k = binary_in: mode 00 sets bit k only; 01 sets bits 0..k; 10 clears bit k only and sets all other bits to 1.
REQ-017 SHALL produce an all-zero word with range_err=1 when k >= OUT_W or mode=11, whatever the value of enable.
REQ-018 SHALL produce an all-zero word with range_err=0 when enable=0 and the word is otherwise legal, including mode 10.
REQ-019 SHALL buffer words in a 2-entry FIFO (skid), with decoder_out/range_err driven directly from registers of the head entry and no combinational path from inputs to outputs.
REQ-020 SHALL have a latency of 1 cycle: a word accepted at edge n into an empty buffer SHALL show out_valid=1 from edge n onward.
REQ-021 SHALL pop the head entry on an edge where out_valid and out_ready are both 1.
REQ-022 SHALL be registered in_ready: 1 after an edge that leaves occupancy below 2, 0 after an edge that leaves occupancy equal to 2, so there is no combinational path from out_ready to in_ready.
REQ-023 SHALL, on a simultaneous push and pop, leave occupancy unchanged and preserve order (strict FIFO, no reordering or loss).
REQ-024 SHALL hold decoder_out, range_err and out_valid stable while out_valid=1 and out_ready=0.
REQ-025 SHALL drive decoder_out to all zeros whenever out_valid=0.
REQ-026 SHALL increment err_cnt on acceptance of a word with range_err, saturating at 255 with no wrap.
REQ-027 SHALL sustain full throughput of 1 word per cycle when out_ready is held at 1.

Reset
REQ-028 SHALL, while reset=1, immediately force in_ready=0, out_valid=0, decoder_out=0, range_err=0, err_cnt=0 and occupancy=0.
REQ-029 SHALL, when reset is asserted mid-operation, discard all buffered words with no partial output.
REQ-030 SHALL raise in_ready to 1 at the first rising edge after reset deasserts.

Verification
REQ-031 SHALL cover one-hot decode: defaults, mode=00, enable=1, binary_in=4'hA, out_ready=1 -> next cycle decoder_out=16'h0400, range_err=0.
REQ-032 SHALL cover thermometer and inverted decode: binary_in=3 in mode 01 -> 16'h000F; binary_in=3 in mode 10 -> 16'hFFF7; binary_in=3 in mode 10 with enable=0 -> 16'h0000, range_err=0.
REQ-033 SHALL cover range and mode errors: OUT_W=10, binary_in=12 -> decoder_out=0, range_err=1, err_cnt=1; 300 further errors -> err_cnt=255.
REQ-034 SHALL cover backpressure: out_ready=0, stream words 1,2,3 -> in_ready=0 after 2 accepts; release out_ready -> outputs 16'h0002, 16'h0004, 16'h0008 in order, none lost.
REQ-035 SHALL cover throughput: out_ready=1, 16 back-to-back words 0..15 -> 16 consecutive out_valid cycles, each decoder_out correct.
REQ-036 SHALL cover reset mid-operation: reset pulse with 2 words buffered -> out_valid=0 immediately, in_ready=1 one edge after release, no stale word is ever output.
